fifo_addr_control: RTL and testbench

- Read/write address generator for a small circular FIFO storage array, e.g. the index FIFO beside a parallel-indices comparison unit.
- Keeps independent write and read pointers, an occupancy count, and full/empty status.
- The parent block owns the storage array and indexes it with waddr/raddr.
- Single clock domain; no storage inside this block.

---
 rtl/fifo_addr_control.sv | 111 +++++++++++
 tb/tb_fifo_addr_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_addr_control.sv
// fifo_addr_control: write/read address generator for a small circular FIFO.
// The parent owns the storage array and indexes it with waddr/raddr. This
// block holds the pointers, the occupancy count and the full/empty status.
// Optional sticky overflow/underflow flags are enabled by defining
// FIFO_ADDR_CTRL_ERR_FLAGS_EN. Without it, ovf/udf are tied low.
module fifo_addr_control #(
    parameter int unsigned ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              wr_acc,
    output logic              rd_acc,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CNT_W-1:0]  w_count_nxt;

    // Accept logic: a read at full frees a slot, so the write goes through.
    // There is no write-to-read bypass, so a read at empty is always refused.
    always_comb begin
        w_wr_acc = wr_en && (!r_full || rd_en);
        w_rd_acc = rd_en && !r_empty;
    end

    // Next occupancy from the accepted requests only.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and status. full/empty come from the next count so that
    // they line up with count in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_waddr <= r_waddr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_raddr <= r_raddr + ADDR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

`ifdef FIFO_ADDR_CTRL_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    // Sticky error flags: a refused write sets ovf, a read at empty sets udf.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && !w_wr_acc) begin
                r_ovf <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign waddr  = r_waddr;
    assign raddr  = r_raddr;
    assign wr_acc = w_wr_acc;
    assign rd_acc = w_rd_acc;
    assign count  = r_count;
    assign full   = r_full;
    assign empty  = r_empty;

endmodule

// File: tb/tb_fifo_addr_control.sv
// Bench for fifo_addr_control: depth-2 and depth-8 instances driven by a
// directed sequence, checked against a behavioural model via a scoreboard.
module tb_fifo_addr_control;

    logic clk;
    logic rst_n;

    // depth-2 instance
    logic       a_wr_en, a_rd_en;
    logic [0:0] a_waddr, a_raddr;
    logic       a_wr_acc, a_rd_acc;
    logic [1:0] a_count;
    logic       a_full, a_empty, a_ovf, a_udf;

    // depth-8 instance
    logic       b_wr_en, b_rd_en;
    logic [2:0] b_waddr, b_raddr;
    logic       b_wr_acc, b_rd_acc;
    logic [3:0] b_count;
    logic       b_full, b_empty, b_ovf, b_udf;

    fifo_addr_control #(.ADDR_W(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .rd_en(a_rd_en),
        .waddr(a_waddr), .raddr(a_raddr), .wr_acc(a_wr_acc), .rd_acc(a_rd_acc),
        .count(a_count), .full(a_full), .empty(a_empty), .ovf(a_ovf), .udf(a_udf)
    );

    fifo_addr_control #(.ADDR_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .rd_en(b_rd_en),
        .waddr(b_waddr), .raddr(b_raddr), .wr_acc(b_wr_acc), .rd_acc(b_rd_acc),
        .count(b_count), .full(b_full), .empty(b_empty), .ovf(b_ovf), .udf(b_udf)
    );

`ifdef FIFO_ADDR_CTRL_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int waddr;
        int raddr;
        int count;
        int full;
        int empty;
        int ovf;
        int udf;
    } state_t;

    state_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // model state per instance
    int depth [2] = '{2, 8};
    int m_w   [2];
    int m_r   [2];
    int m_cnt [2];
    int m_ovf [2];
    int m_udf [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int s);
        m_w[s] = 0; m_r[s] = 0; m_cnt[s] = 0; m_ovf[s] = 0; m_udf[s] = 0;
    endtask

    task automatic sample(input int s, output state_t o);
        if (s == 0) begin
            o.waddr = int'(a_waddr); o.raddr = int'(a_raddr); o.count = int'(a_count);
            o.full = int'(a_full); o.empty = int'(a_empty);
            o.ovf = int'(a_ovf); o.udf = int'(a_udf);
        end else begin
            o.waddr = int'(b_waddr); o.raddr = int'(b_raddr); o.count = int'(b_count);
            o.full = int'(b_full); o.empty = int'(b_empty);
            o.ovf = int'(b_ovf); o.udf = int'(b_udf);
        end
    endtask

    // One clock of stimulus on instance s; comb outputs checked in-cycle,
    // registered outputs checked after the edge against the scoreboard.
    task automatic step(input int s, input bit wr, input bit rd, input bit rstv,
                        input bit chk_comb, input string tag);
        int     wacc;
        int     racc;
        state_t e;
        state_t o;
        @(negedge clk);
        rst_n   = rstv;
        a_wr_en = (s == 0) ? wr : 1'b0;
        a_rd_en = (s == 0) ? rd : 1'b0;
        b_wr_en = (s == 1) ? wr : 1'b0;
        b_rd_en = (s == 1) ? rd : 1'b0;
        #1;
        wacc = (wr && (m_cnt[s] < depth[s] || rd)) ? 1 : 0;
        racc = (rd && m_cnt[s] > 0) ? 1 : 0;
        if (chk_comb) begin
            chk({tag, ".wr_acc"}, (s == 0) ? int'(a_wr_acc) : int'(b_wr_acc), wacc);
            chk({tag, ".rd_acc"}, (s == 0) ? int'(a_rd_acc) : int'(b_rd_acc), racc);
            chk({tag, ".waddr_now"}, (s == 0) ? int'(a_waddr) : int'(b_waddr), m_w[s]);
            chk({tag, ".raddr_now"}, (s == 0) ? int'(a_raddr) : int'(b_raddr), m_r[s]);
        end
        if (!rstv) begin
            model_reset(0);
            model_reset(1);
        end else begin
            if (ERR_EN && wr && wacc == 0) m_ovf[s] = 1;
            if (ERR_EN && rd && m_cnt[s] == 0) m_udf[s] = 1;
            if (wacc == 1) m_w[s] = (m_w[s] + 1) % depth[s];
            if (racc == 1) m_r[s] = (m_r[s] + 1) % depth[s];
            m_cnt[s] = m_cnt[s] + wacc - racc;
        end
        e.waddr = m_w[s]; e.raddr = m_r[s]; e.count = m_cnt[s];
        e.full  = (m_cnt[s] == depth[s]) ? 1 : 0;
        e.empty = (m_cnt[s] == 0) ? 1 : 0;
        e.ovf   = m_ovf[s]; e.udf = m_udf[s];
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        sample(s, o);
        if (exp_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".waddr"}, o.waddr, e.waddr);
            chk({tag, ".raddr"}, o.raddr, e.raddr);
            chk({tag, ".count"}, o.count, e.count);
            chk({tag, ".full"},  o.full,  e.full);
            chk({tag, ".empty"}, o.empty, e.empty);
            chk({tag, ".ovf"},   o.ovf,   e.ovf);
            chk({tag, ".udf"},   o.udf,   e.udf);
            chk({tag, ".invariant"}, o.waddr, (o.raddr + o.count) % depth[s]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        model_reset(0);
        model_reset(1);

        // reset held two cycles with both requests high
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, "reset0");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, "reset1");

        // fill depth-2 past full
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b1, 1'b1, $sformatf("fill%0d", i));
        // drain past empty
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b1, 1'b1, $sformatf("drain%0d", i));
        // refill, then simultaneous at full
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, "refill0");
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, "refill1");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, "simfull0");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, "simfull1");
        // drain, then simultaneous at empty
        step(0, 1'b0, 1'b1, 1'b1, 1'b1, "down0");
        step(0, 1'b0, 1'b1, 1'b1, 1'b1, "down1");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, "simempty");
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, "idle");
        // reset mid-operation with requests active
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, "midreset");
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, "postreset");

        // depth-8: writes interleaved with reads, crossing the wrap point
        for (int i = 0; i < 30; i++)
            step(1, (i % 3) != 2, (i % 4) == 3, 1'b1, 1'b1, $sformatf("wrap%0d", i));
        for (int i = 0; i < 10; i++)
            step(1, (i % 5) == 0, 1'b1, 1'b1, 1'b1, $sformatf("wdrain%0d", i));
        for (int i = 0; i < 12; i++)
            step(1, 1'b1, (i % 2) == 1, 1'b1, 1'b1, $sformatf("wfill%0d", i));

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
